apb_requester: RTL

APB requester (initiator) that turns a single-command valid/ready request into one APB3 transfer and returns the result on a valid/ready response channel. It is the driving end of the APB completer interface (PSEL/PENABLE/PREADY) used by the existing peripheral blocks. It is intended for equivalence and bring-up benches and as the bus front end for small controllers. It allows one outstanding transfer at a time.

---
 rtl/apb_requester.sv | 139 +++++++++++++
 1 files changed

// File: rtl/apb_requester.sv
// APB3 requester: accepts one command on a valid/ready channel, runs a
// single SETUP/ACCESS transfer on the bus and returns the result on a
// valid/ready response channel. One transfer outstanding at a time.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        wait_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_error_q;
  logic                    rsp_timeout_q;
  logic                    timeout_hit;

  // Abort when this PREADY=0 cycle would bring the wait count to the limit.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  ((32'(wait_q) + 32'd1) == 32'(TIMEOUT_CYCLES));
  end

  // Transfer sequencer with registered bus and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            wait_q   <= '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_error_q   <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else begin
            if (wait_q != '1) begin
              wait_q <= wait_q + CNT_W'(1);
            end
            if (timeout_hit) begin
              rsp_rdata_q   <= '0;
              rsp_error_q   <= 1'b1;
              rsp_timeout_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              state_q       <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            wait_q      <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
